// File: rtl/dac_stream_sched.sv
// dac_stream_sched: DAC output sequencer.
// Divides clk into the DAC clock and runs an IDLE/WARMUP/RUN/STOPPING
// state machine. Every DAC period (slot) presents one sample on dout,
// taken from an internal ramp or from an external valid/ready stream.
module dac_stream_sched #(
  parameter int unsigned              DOUT_WIDTH     = 14,
  parameter int unsigned              DAC_CLK_FACTOR = 8,
  parameter int unsigned              WARMUP_PERIODS = 2,
  parameter logic [DOUT_WIDTH-1:0]    RAMP_STEP      = DOUT_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  src_sel,
  input  logic [DOUT_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  dac_clk,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  underrun,
  output logic [15:0]           underrun_cnt
);

  if (DAC_CLK_FACTOR < 2 || (DAC_CLK_FACTOR % 2) != 0) begin : g_bad_factor
    $error("dac_stream_sched: DAC_CLK_FACTOR must be even and >= 2");
  end

  localparam int unsigned PW = (DAC_CLK_FACTOR > 2) ? $clog2(DAC_CLK_FACTOR) : 1;
  localparam int unsigned WC = (WARMUP_PERIODS > 1) ? $clog2(WARMUP_PERIODS) : 1;

  localparam logic [PW-1:0]         PH_LAST = PW'(DAC_CLK_FACTOR - 1);
  localparam logic [PW-1:0]         PH_HALF = PW'(DAC_CLK_FACTOR / 2);
  localparam logic [WC-1:0]         WLAST   = WC'((WARMUP_PERIODS > 0) ? WARMUP_PERIODS - 1 : 0);
  localparam logic [DOUT_WIDTH-1:0] MID     = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WARMUP, RUN, STOPPING} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         ph_q, ph_d;
  logic [WC-1:0]         warm_q, warm_d;
  logic                  pend_q, pend_d;
  logic                  src_q, src_d;
  logic [DOUT_WIDTH-1:0] ramp_q, ramp_d;
  logic [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                  dac_clk_q, dac_clk_d;
  logic                  underrun_q, underrun_d;
  logic [15:0]           ucnt_q, ucnt_d;

  logic                  last_ph;
  logic                  next_is_run;
  logic                  fire;
  logic                  src_eff;
  logic [DOUT_WIDTH-1:0] ramp_base;

  // Fetch strobe is a pure function of registered state, never of s_valid.
  assign last_ph     = (ph_q == PH_LAST);
  assign next_is_run = (state_q == RUN) || ((state_q == WARMUP) && (warm_q == WLAST));
  assign s_ready     = next_is_run && last_ph && src_q && !pend_q;
  assign fire        = s_ready && s_valid;

  // On the accepting start cycle the latched source/ramp are not yet visible.
  assign src_eff   = (state_q == IDLE) ? src_sel : src_q;
  assign ramp_base = (state_q == IDLE) ? '0 : ramp_q;

  assign busy         = (state_q != IDLE);
  assign dac_clk      = dac_clk_q;
  assign dout         = dout_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = ucnt_q;

  // Next-state: FSM transitions, phase counter, sample selection and outputs.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    warm_d  = warm_q;
    pend_d  = pend_q;
    src_d   = src_q;
    ramp_d  = ramp_q;
    dout_d  = dout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_sel;
          ramp_d  = '0;
          warm_d  = '0;
          pend_d  = 1'b0;
          state_d = (WARMUP_PERIODS == 0) ? RUN : WARMUP;
        end
      end
      WARMUP: begin
        if (stop) pend_d = 1'b1;
        if (last_ph) begin
          if (pend_q) begin
            state_d = STOPPING;
            pend_d  = 1'b0;
          end else if (warm_q == WLAST) begin
            state_d = RUN;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) pend_d = 1'b1;
        if (last_ph && pend_q) begin
          state_d = STOPPING;
          pend_d  = 1'b0;
        end
      end
      STOPPING: begin
        if (last_ph) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE || state_d == IDLE) ph_d = '0;
    else                                    ph_d = last_ph ? '0 : ph_q + 1'b1;

    // dout only moves when the next cycle is a slot start (ph=0).
    if (state_d == IDLE) begin
      dout_d = '0;
    end else if (ph_d == '0) begin
      unique case (state_d)
        WARMUP, STOPPING: dout_d = MID;
        RUN: begin
          if (!src_eff) begin
            dout_d = ramp_base;
            ramp_d = ramp_base + RAMP_STEP;
          end else if (fire) begin
            dout_d = s_data;
          end
        end
        default: ;
      endcase
    end

    dac_clk_d  = (state_d != IDLE) && (ph_d >= PH_HALF);
    underrun_d = s_ready && !s_valid;
    ucnt_d     = (underrun_d && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      warm_q     <= '0;
      pend_q     <= 1'b0;
      src_q      <= 1'b0;
      ramp_q     <= '0;
      dout_q     <= '0;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      warm_q     <= warm_d;
      pend_q     <= pend_d;
      src_q      <= src_d;
      ramp_q     <= ramp_d;
      dout_q     <= dout_d;
      dac_clk_q  <= dac_clk_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

endmodule

// File: tb/tb_dac_stream_sched.sv
// Directed bench for dac_stream_sched (FACTOR=8, W=14, WARMUP=2).
// Expected slot samples are queued when stimulus is driven and popped at
// each slot start (ph=0) to compare against dout.
module tb_dac_stream_sched;

  localparam logic [13:0] MID = 14'd8192;

  logic        clk = 1'b0;
  logic        rst, start, stop, src_sel, s_valid;
  logic [13:0] s_data;
  logic        s_ready, dac_clk, busy, underrun;
  logic [13:0] dout;
  logic [15:0] underrun_cnt;

  logic        w_rst, w_start, w_stop, w_src, w_s_valid;
  logic [13:0] w_s_data;
  logic        w_s_ready, w_dac_clk, w_busy, w_underrun;
  logic [13:0] w_dout;
  logic [15:0] w_underrun_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [13:0] exp_q[$];
  logic [13:0] nd;
  logic [13:0] stream_last;

  always #5 clk = ~clk;

  dac_stream_sched #(
    .DOUT_WIDTH(14), .DAC_CLK_FACTOR(8), .WARMUP_PERIODS(2), .RAMP_STEP(14'd1)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .src_sel(src_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .dac_clk(dac_clk),
    .dout(dout), .busy(busy), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  dac_stream_sched #(
    .DOUT_WIDTH(14), .DAC_CLK_FACTOR(8), .WARMUP_PERIODS(2), .RAMP_STEP(14'h1000)
  ) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start), .stop(w_stop), .src_sel(w_src),
    .s_data(w_s_data), .s_valid(w_s_valid), .s_ready(w_s_ready), .dac_clk(w_dac_clk),
    .dout(w_dout), .busy(w_busy), .underrun(w_underrun), .underrun_cnt(w_underrun_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dacclk"}, 32'(dac_clk), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sready"}, 32'(s_ready), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  // Accept a start from IDLE; src_sel is flipped afterwards to show it was latched.
  task automatic go(input logic src);
    chk("go_idle_busy", 32'(busy), 32'd0);
    src_sel = src;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    src_sel = ~src;
    chk("go_busy", 32'(busy), 32'd1);
  endtask

  // One slot of 8 cycles, entered at its ph=0 cycle.
  task automatic slot(input string tag, input bit sr_exp, input bit sv, input bit ur_exp,
                      input int start_at, input int stop_at);
    logic [13:0] ref_d;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(1), 32'(0));
      ref_d = 14'h0;
    end else begin
      ref_d = exp_q.pop_front();
    end
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_dout"}, 32'(dout), 32'(ref_d));
      chk({tag, "_dacclk"}, 32'(dac_clk), (k >= 4) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_sready"}, 32'(s_ready), (k == 7 && sr_exp) ? 32'd1 : 32'd0);
      chk({tag, "_underrun"}, 32'(underrun), (k == 0 && ur_exp) ? 32'd1 : 32'd0);
      start   = (k == start_at);
      stop    = (k == stop_at);
      s_valid = 1'b0;
      if (k == 7) begin
        s_valid = sv;
        if (sr_exp) begin
          if (sv) begin
            s_data      = nd;
            exp_q.push_back(nd);
            stream_last = nd;
            nd          = nd + 14'd1;
          end else begin
            exp_q.push_back(stream_last);
          end
        end
      end
      tick();
    end
    start   = 1'b0;
    stop    = 1'b0;
    s_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; src_sel = 1'b0; s_valid = 1'b0; s_data = '0;
    w_rst = 1'b1; w_start = 1'b0; w_stop = 1'b0; w_src = 1'b0; w_s_valid = 1'b0; w_s_data = '0;
    nd = 14'h100; stream_last = '0;
    tick();
    tick();
    idle_chk("reset");
    chk("reset_cnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b0; w_rst = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    idle_chk("idle_stop_ignored");

    // Ramp source; start during RUN and during STOPPING must be ignored.
    go(1'b0);
    exp_q.push_back(MID); slot("ramp_wu0", 0, 0, 0, -1, -1);
    exp_q.push_back(MID); slot("ramp_wu1", 0, 0, 0, -1, -1);
    exp_q.push_back(14'd0); slot("ramp_r0", 0, 0, 0, -1, -1);
    exp_q.push_back(14'd1); slot("ramp_r1", 0, 0, 0, 5, -1);
    exp_q.push_back(14'd2); slot("ramp_r2", 0, 0, 0, -1, -1);
    exp_q.push_back(14'd3); slot("ramp_r3", 0, 0, 0, -1, 3);
    exp_q.push_back(MID); slot("ramp_stp", 0, 0, 0, 2, -1);
    idle_chk("ramp_idle");
    tick();
    idle_chk("ramp_idle2");

    // Stream source with one underrun, then stop.
    go(1'b1);
    exp_q.push_back(MID); slot("str_wu0", 0, 0, 0, -1, -1);
    exp_q.push_back(MID); slot("str_wu1", 1, 1, 0, -1, -1);
    slot("str_a", 1, 1, 0, -1, -1);
    chk("str_cnt0", 32'(underrun_cnt), 32'd0);
    slot("str_b", 1, 0, 0, -1, -1);
    chk("str_ur_cnt1", 32'(underrun_cnt), 32'd1);
    slot("str_c", 1, 1, 1, -1, -1);
    slot("str_d", 0, 0, 0, -1, 3);
    exp_q.push_back(MID); slot("str_stp", 0, 0, 0, 4, -1);
    idle_chk("str_idle");
    chk("str_cnt_hold", 32'(underrun_cnt), 32'd1);

    // Reset at RUN ph=3, then a fresh ramp run.
    go(1'b0);
    exp_q.push_back(MID); slot("rst_wu0", 0, 0, 0, -1, -1);
    exp_q.push_back(MID); slot("rst_wu1", 0, 0, 0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      chk("rst_run_dout", 32'(dout), 32'd0);
      rst = (k == 3);
      tick();
    end
    rst = 1'b0;
    idle_chk("rst_mid");
    chk("rst_mid_cnt", 32'(underrun_cnt), 32'd0);
    go(1'b0);
    exp_q.push_back(MID); slot("re_wu0", 0, 0, 0, -1, -1);
    exp_q.push_back(MID); slot("re_wu1", 0, 0, 0, -1, -1);
    exp_q.push_back(14'd0); slot("re_r0", 0, 0, 0, -1, -1);
    exp_q.push_back(14'd1); slot("re_r1", 0, 0, 0, -1, 1);
    exp_q.push_back(MID); slot("re_stp", 0, 0, 0, -1, -1);
    idle_chk("re_idle");

    // Ramp wrap on the RAMP_STEP=0x1000 instance.
    chk("wrap_idle_dout", 32'(w_dout), 32'd0);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    chk("wrap_busy", 32'(w_busy), 32'd1);
    exp_q.push_back(14'h0000);
    exp_q.push_back(14'h1000);
    exp_q.push_back(14'h2000);
    exp_q.push_back(14'h3000);
    exp_q.push_back(14'h0000);
    for (int c = 0; c < 16; c++) tick();
    for (int s = 0; s < 5; s++) begin
      chk("wrap_dout", 32'(w_dout), 32'(exp_q.pop_front()));
      for (int c = 0; c < 8; c++) tick();
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
